// File: rtl/sequencer_scheduler_pkg.sv
// Shared definitions for the sequencer scheduler: FSM encoding and the
// half-period clamp applied when a burst is granted.
package sequencer_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4
    } state_t;

    localparam int MIN_HALF_PERIOD = 4;

    // Shorter phases do not give the sequencer enough time to register a trigger edge.
    function automatic logic [31:0] clamp_half_period(input logic [31:0] hp);
        return (hp < 32'(MIN_HALF_PERIOD)) ? 32'(MIN_HALF_PERIOD) : hp;
    endfunction

endpackage

// File: rtl/sequencer_scheduler_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// the slot after LAST, wrapping around.
module sequencer_scheduler_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [$clog2(NUM_REQ)-1:0] LAST,
    output logic [$clog2(NUM_REQ)-1:0] WINNER,
    output logic                       ANY
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] w_idx;

    always_comb begin
        WINNER = '0;
        ANY    = 1'b0;
        w_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IW'((int'(LAST) + i) % NUM_REQ);
            if (!ANY && REQ[w_idx]) begin
                ANY    = 1'b1;
                WINNER = w_idx;
            end
        end
    end

endmodule

// File: rtl/sequencer_scheduler.sv
// Grants one requester at a time to the shared serializing sequencer, loads its
// vector with a one-cycle valid and then plays out NUM_INPUTS trigger pulses.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a request; arbitrates and captures the winner
//   ST_LOAD   | one cycle: REQ_READY / SEQ_VALID_OUT to the granted slot
//   ST_SETTLE | hp cycles trigger low so the sequencer leaves its idle state
//   ST_HIGH   | hp cycles trigger high
//   ST_LOW    | hp cycles trigger low; counts the pulse, loops or finishes
module sequencer_scheduler
    import sequencer_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 8,
    parameter int HP_W       = 8
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [NUM_REQ*NUM_INPUTS*WIDTH-1:0] REQ_VALUES,
    input  logic [NUM_REQ-1:0]                  REQ_VALID,
    output logic [NUM_REQ-1:0]                  REQ_READY,
    input  logic [HP_W-1:0]                     HALF_PERIOD,
    output logic [NUM_INPUTS*WIDTH-1:0]         SEQ_VALUES_OUT,
    output logic                                SEQ_VALID_OUT,
    output logic                                SEQ_TRIGGER,
    output logic [$clog2(NUM_REQ)-1:0]          GRANT_ID,
    output logic                                BUSY,
    output logic                                DONE
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int VW = NUM_INPUTS * WIDTH;
    localparam int PW = $clog2(NUM_INPUTS + 1);
    localparam logic [PW-1:0] LAST_PULSE = PW'(NUM_INPUTS - 1);

    state_t          r_state, w_next;
    logic [IW-1:0]   r_last, r_grant, w_winner;
    logic            w_any;
    logic [VW-1:0]   r_vec;
    logic [HP_W-1:0] r_hp, r_phase;
    logic [PW-1:0]   r_pulses;
    logic            r_trig, r_done;
    logic            w_phase_end;
    logic [NUM_REQ-1:0] w_ready;

    sequencer_scheduler_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .REQ    (REQ_VALID),
        .LAST   (r_last),
        .WINNER (w_winner),
        .ANY    (w_any)
    );

    assign w_phase_end = (r_phase == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_next = ST_LOAD;
            ST_LOAD:   w_next = ST_SETTLE;
            ST_SETTLE: if (w_phase_end) w_next = ST_HIGH;
            ST_HIGH:   if (w_phase_end) w_next = ST_LOW;
            ST_LOW: begin
                if (w_phase_end) begin
                    w_next = (r_pulses == LAST_PULSE) ? ST_IDLE : ST_HIGH;
                end
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_last   <= IW'(NUM_REQ - 1);
            r_grant  <= '0;
            r_vec    <= '0;
            r_hp     <= '0;
            r_phase  <= '0;
            r_pulses <= '0;
            r_trig   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_trig  <= (w_next == ST_HIGH);
            r_done  <= (r_state == ST_LOW) && (w_next == ST_IDLE);

            if (r_state == ST_IDLE && w_any) begin
                r_vec   <= REQ_VALUES[int'(w_winner)*VW +: VW];
                r_hp    <= HP_W'(clamp_half_period(32'(HALF_PERIOD)));
                r_grant <= w_winner;
                r_last  <= w_winner;
            end

            // Every phase change restarts the down-counter from the latched half-period.
            if (w_next != r_state) begin
                r_phase <= r_hp - HP_W'(1);
            end else if (!w_phase_end) begin
                r_phase <= r_phase - HP_W'(1);
            end

            if (r_state == ST_LOAD) begin
                r_pulses <= '0;
            end else if (r_state == ST_LOW && w_phase_end) begin
                r_pulses <= r_pulses + PW'(1);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == ST_LOAD) w_ready[r_grant] = 1'b1;
    end

    assign REQ_READY      = w_ready;
    assign SEQ_VALID_OUT  = (r_state == ST_LOAD);
    assign SEQ_VALUES_OUT = r_vec;
    assign SEQ_TRIGGER    = r_trig;
    assign GRANT_ID       = r_grant;
    assign BUSY           = (r_state != ST_IDLE);
    assign DONE           = r_done;

endmodule

// File: tb/tb_sequencer_scheduler.sv
// Bench for sequencer_scheduler: directed timing scenarios plus random traffic,
// all cycles checked against a burst-timeline reference model.
module tb_sequencer_scheduler;
    localparam int NR  = 2;
    localparam int NI  = 4;
    localparam int W   = 8;
    localparam int HPW = 8;
    localparam int VW  = NI * W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR*VW-1:0] req_values = '0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [HPW-1:0]   half_period = 8'd4;
    logic [VW-1:0]    seq_values;
    logic             seq_valid, seq_trig, busy, done;
    logic [0:0]       grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sequencer_scheduler #(
        .NUM_REQ(NR), .NUM_INPUTS(NI), .WIDTH(W), .HP_W(HPW)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .REQ_VALUES     (req_values),
        .REQ_VALID      (req_valid),
        .REQ_READY      (req_ready),
        .HALF_PERIOD    (half_period),
        .SEQ_VALUES_OUT (seq_values),
        .SEQ_VALID_OUT  (seq_valid),
        .SEQ_TRIGGER    (seq_trig),
        .GRANT_ID       (grant_id),
        .BUSY           (busy),
        .DONE           (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a burst granted in cycle s with half-period hp occupies
    // s+1 (load), then hp settle cycles, then NI high/low pairs, DONE at s+2+hp+2*hp*NI.
    int            cyc = 0;
    bit            m_act = 1'b0;
    int            m_start = 0, m_hp = 4, m_win = 0, m_last = NR - 1, m_gid = 0;
    logic [VW-1:0] m_vec = '0;

    always @(negedge clk) begin
        int d, l_done;
        bit live, found;
        logic [NR-1:0] e_ready;
        logic e_trig;
        d      = cyc - m_start;
        l_done = 2 + m_hp + 2 * m_hp * NI;
        live   = m_act && (d <= l_done);
        e_ready = '0;
        if (live && d == 1) e_ready[m_win] = 1'b1;
        e_trig = live && (d >= 2 + m_hp) && (d < l_done) && (((d - 2 - m_hp) / m_hp) % 2 == 0);

        chk("ready",    req_ready, e_ready);
        chk("seqvalid", seq_valid, live && d == 1);
        chk("trigger",  seq_trig, e_trig);
        chk("busy",     busy, live && d >= 1 && d < l_done);
        chk("done",     done, live && d == l_done);
        chk("grant_id", grant_id, m_gid);
        chk("values",   seq_values, m_vec);

        if (rst) begin
            m_act  = 1'b0;
            m_last = NR - 1;
            m_gid  = 0;
            m_vec  = '0;
        end else if (!(live && d < l_done) && (req_valid != '0)) begin
            found = 1'b0;
            for (int i = 1; i <= NR; i++) begin
                if (!found && req_valid[(m_last + i) % NR]) begin
                    found = 1'b1;
                    m_win = (m_last + i) % NR;
                end
            end
            m_act   = 1'b1;
            m_start = cyc;
            m_hp    = (half_period < 4) ? 4 : int'(half_period);
            m_last  = m_win;
            m_gid   = m_win;
            m_vec   = req_values[m_win*VW +: VW];
        end
        cyc++;
    end

    // Raises one request in the current cycle (t) and reports k where t+k
    // saw the first trigger rise and DONE.
    task automatic run_burst(input int req, input logic [31:0] vec, input int hp0,
                             input int chg_at, input int hp1, input int rst_at,
                             output int done_k, output int rise_k);
        logic prev_trig;
        done_k = -1;
        rise_k = -1;
        prev_trig = 1'b0;
        req_values[req*VW +: VW] = vec;
        half_period = HPW'(hp0);
        req_valid[req] = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            rst = (k == rst_at);
            if (k == chg_at) half_period = HPW'(hp1);
            if (k == 1) begin
                chk("load_ready", req_ready, 2'b01 << req);
                chk("load_vec", seq_values, vec);
            end
            if (rst_at > 0 && k == rst_at + 1)
                chk("rst_outputs", {busy, seq_trig, done, seq_valid, req_ready, grant_id}, '0);
            if (req_ready[req]) req_valid[req] = 1'b0;
            if (seq_trig && !prev_trig && rise_k < 0) rise_k = k;
            prev_trig = seq_trig;
            if (done) begin
                done_k = k;
                break;
            end
            if (rst_at > 0 && k > rst_at + 2) break;
        end
    endtask

    initial begin
        int dk, rk;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_burst(0, 32'h44332211, 4, -1, 4, -1, dk, rk);
        chk("s1_rise", rk, 6);
        chk("s1_done", dk, 38);

        run_burst(0, 32'hA5C3_0F96, 1, -1, 1, -1, dk, rk);
        chk("s3_clamp_rise", rk, 6);
        chk("s3_clamp_done", dk, 38);

        run_burst(0, 32'h1234_5678, 6, -1, 6, -1, dk, rk);
        chk("s3_hp6_rise", rk, 8);
        chk("s3_hp6_done", dk, 56);

        run_burst(0, 32'hDEAD_BEEF, 4, 10, 10, -1, dk, rk);
        chk("s4_rise", rk, 6);
        chk("s4_done", dk, 38);

        run_burst(0, 32'h0BAD_F00D, 4, -1, 4, 20, dk, rk);
        chk("s5_no_done", dk, -1);

        begin
            int grants[$];
            int last_done, n_done;
            last_done = -1;
            n_done = 0;
            half_period = 8'd4;
            req_valid = 2'b11;
            for (int k = 1; k <= 400 && n_done < 4; k++) begin
                @(posedge clk); #1;
                if (req_ready != '0) begin
                    grants.push_back(int'(grant_id));
                    if (last_done > 0) chk("s2_gap", k - last_done, 1);
                    if (grants.size() == 4) req_valid = '0;
                end
                if (done) begin
                    last_done = k;
                    n_done++;
                end
            end
            chk("s2_bursts", n_done, 4);
            for (int i = 0; i < 4; i++)
                chk("s2_grant", (i < grants.size()) ? grants[i] : -1, i % 2);
        end

        begin
            int d0, d1, r1;
            d0 = -1; d1 = -1; r1 = -1;
            req_values[0 +: VW] = $urandom();
            req_valid[0] = 1'b1;
            for (int k = 1; k <= 200; k++) begin
                @(posedge clk); #1;
                if (k == 10) begin
                    req_values[VW +: VW] = $urandom();
                    req_valid[1] = 1'b1;
                end
                if (req_ready[0]) req_valid[0] = 1'b0;
                if (req_ready[1]) begin
                    r1 = k;
                    req_valid[1] = 1'b0;
                end
                if (done) begin
                    if (d0 < 0) d0 = k;
                    else begin
                        d1 = k;
                        break;
                    end
                end
            end
            chk("s6_first_done", d0, 38);
            chk("s6_late_ready", r1, d0 + 1);
            chk("s6_second_done", d1, d0 + 38);
        end

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0) half_period = HPW'($urandom_range(0, 9));
            for (int r = 0; r < NR; r++) begin
                if (req_ready[r]) req_valid[r] = 1'b0;
                else if (!req_valid[r] && $urandom_range(0, 19) == 0) begin
                    req_values[r*VW +: VW] = $urandom();
                    req_valid[r] = 1'b1;
                end
            end
        end

        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 300 && busy; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_idle", busy, 1'b0);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequencer_scheduler.md
# sequencer_scheduler

Shares one downstream serializing sequencer between `NUM_REQ` requesters. Each requester offers a full vector of `NUM_INPUTS` words. The block grants one requester at a time in round-robin order and loads its vector into the sequencer with a one-cycle valid pulse. It then generates exactly `NUM_INPUTS` trigger pulses with a programmable half-period, so the sequencer emits every word, and signals completion. It sits between the requester fabric and the sequencer's `VALUES_IN`/`VALID_IN`/`TRIGGER` inputs.

## Interface

**Parameters**
- `NUM_REQ`, 2: number of requesters (≥2).
- `NUM_INPUTS`, 4: words per vector; must match the sequencer.
- `WIDTH`, 8: word width.
- `HP_W`, 8: width of `HALF_PERIOD`.

**Ports**
- `CLK`, in, 1: single clock; all logic on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `REQ_VALUES`, in, `NUM_REQ*NUM_INPUTS*WIDTH`: requester r's vector at slice `[r*NUM_INPUTS*WIDTH +: NUM_INPUTS*WIDTH]`.
- `REQ_VALID`, in, `NUM_REQ`: per-requester request.
- `REQ_READY`, out, `NUM_REQ`: one-hot, one-cycle acknowledge of the captured request.
- `HALF_PERIOD`, in, `HP_W`: cycles per trigger high/low phase; values below 4 are clamped to 4.
- `SEQ_VALUES_OUT`, out, `NUM_INPUTS*WIDTH`: registered vector sent to the sequencer.
- `SEQ_VALID_OUT`, out, 1: one-cycle load pulse.
- `SEQ_TRIGGER`, out, 1: registered trigger waveform.
- `GRANT_ID`, out, `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `BUSY`, out, 1: high from grant until `DONE`.
- `DONE`, out, 1: one-cycle burst-complete pulse.

## Operation

- Reset values: all outputs are 0. The round-robin pointer `last` = `NUM_REQ-1`, so requester 0 wins first. The FSM goes to IDLE and all counters clear.
- The FSM has five states: IDLE, LOAD, SETTLE, HIGH, LOW.
- **IDLE**
  - If any `REQ_VALID` is set, pick winner w as the first set bit searching from `last+1`, wrapping around.
  - Capture w's vector, the clamped `HALF_PERIOD` (written hp below), and w, then go to LOAD.
  - Set `last` = w.
- **LOAD** (1 cycle): `REQ_READY[w]`=1, `SEQ_VALID_OUT`=1, `BUSY`=1, `GRANT_ID`=w. Then go to SETTLE.
- **SETTLE** (hp cycles): trigger low, giving the sequencer time to leave its idle state. Then go to HIGH.
- **HIGH** (hp cycles): `SEQ_TRIGGER`=1. Then go to LOW.
- **LOW** (hp cycles): `SEQ_TRIGGER`=0. At the end of the phase, increment the pulse counter.
  - If the count is below `NUM_INPUTS`, go to HIGH.
  - Otherwise go to IDLE and pulse `DONE`.
- `REQ_VALID` is ignored outside IDLE. Requesters hold `REQ_VALUES` stable while `REQ_VALID` is high and drop `REQ_VALID` after `REQ_READY`.
- `HALF_PERIOD` changes mid-burst have no effect; the value latched at grant is used for the whole burst.
- The phase counter is `HP_W` bits and reloads at each phase start. The pulse counter is `$clog2(NUM_INPUTS+1)` bits.
- The sequencer's active-low reset is tied to `~RST` at the top level. Any `RST` mid-burst aborts immediately: trigger low, no `DONE`, pointer reset.

## Timing

- Request seen in IDLE at cycle t → LOAD at t+1 (`REQ_READY`, `SEQ_VALID_OUT`).
- Trigger rises at t+2+hp.
- Each high phase and each low phase is exactly hp cycles.
- `DONE` and IDLE at t+2+hp+2·hp·`NUM_INPUTS`.
- A new request may be arbitrated in the `DONE` cycle, giving back-to-back bursts with no gap beyond LOAD.
- `BUSY` is high from t+1 through the last LOW cycle and low in the `DONE` cycle.
- `GRANT_ID` holds its value until the next grant.
- Simultaneous requests are resolved only by the round-robin order. A single persistent requester is re-granted every burst.

## Structure

- **Shared package:** FSM state encodings; `MIN_HALF_PERIOD` = 4; the clamp function for `HALF_PERIOD`.
- **Sub-module:** `ROUND_ROBIN_ARBITER`, parameterized on `NUM_REQ`.
  - Inputs: `REQ`, `LAST`.
  - Outputs: `WINNER` index and `ANY` flag.
  - Purely combinational.
  - The pointer register stays in the scheduler.

## Test plan

All scenarios use `NUM_REQ`=2, `NUM_INPUTS`=4, `WIDTH`=8, `HALF_PERIOD`=4, with the real sequencer attached.

1. **Single request.** Requester 0 sends vector 0x44332211.
   - `REQ_READY`=01 at t+1.
   - Trigger rises at t+6, t+14, t+22, t+30.
   - Sequencer outputs 0x11, 0x22, 0x33, 0x44.
   - `DONE` at t+38.
2. **Simultaneous requests.** Both requesters are held valid from reset.
   - Grants go 0, 1, 0, 1 on consecutive bursts.
   - `DONE`-to-`REQ_READY` gap is 1 cycle.
3. **Clamp.** `HALF_PERIOD`=1.
   - Phases last 4 cycles, identical to scenario 1.
   - With `HALF_PERIOD`=6, `DONE` is at t+56.
4. **Mid-burst change.** `HALF_PERIOD` changes from 4 to 10 at t+10.
   - Timing is unchanged; `DONE` stays at t+38.
5. **Reset mid-burst.** `RST` is asserted at t+20.
   - Next cycle: all outputs 0, no `DONE`.
   - After release, requester 0 wins first again.
6. **Late request.** Requester 1 raises `REQ_VALID` during requester 0's burst.
   - It is ignored until the `DONE` cycle.
   - Granted in that cycle; `REQ_READY`=10 the next cycle.
